// File: rtl/latency_aware_write_master.sv
// Avalon-MM write master: user words are queued in a show-ahead FIFO and posted
// as word-sized writes from a programmed base address until the byte length is exhausted.
`timescale 1ns/1ps
module latency_aware_write_master #(
  parameter int unsigned DATAWIDTH       = 32,
  parameter int unsigned BYTEENABLEWIDTH = 4,
  parameter int unsigned ADDRESSWIDTH    = 32,
  parameter int unsigned FIFODEPTH       = 32,
  parameter int unsigned FIFODEPTH_LOG2  = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       control_fixed_location,
  input  logic [ADDRESSWIDTH-1:0]    control_write_base,
  input  logic [ADDRESSWIDTH-1:0]    control_write_length,
  input  logic                       control_go,
  output logic                       control_done,
  input  logic                       user_write_buffer,
  input  logic [DATAWIDTH-1:0]       user_buffer_data,
  output logic                       user_buffer_full,
  output logic [ADDRESSWIDTH-1:0]    master_address,
  output logic                       master_write,
  output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
  output logic [DATAWIDTH-1:0]       master_writedata,
  input  logic                       master_waitrequest
);

  localparam int unsigned USEDW = FIFODEPTH_LOG2 + 1;
  localparam logic [ADDRESSWIDTH-1:0] STEP     = ADDRESSWIDTH'(BYTEENABLEWIDTH);
  localparam logic [ADDRESSWIDTH-1:0] LEN_MASK = ~ADDRESSWIDTH'(BYTEENABLEWIDTH - 1);

  logic [ADDRESSWIDTH-1:0]   address_q, address_d;
  logic [ADDRESSWIDTH-1:0]   length_q, length_d;
  logic                      fixed_q, fixed_d;
  logic [FIFODEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFODEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [USEDW-1:0]          used_q, used_d;
  logic [DATAWIDTH-1:0]      mem_q [FIFODEPTH];

  logic full_c, push_c, write_c, accept_c;

  assign full_c   = (used_q == USEDW'(FIFODEPTH));
  assign push_c   = user_write_buffer & ~full_c;
  assign write_c  = (length_q != '0) & (used_q != '0);
  assign accept_c = write_c & ~master_waitrequest;

  // Next-state for FIFO bookkeeping and transfer control.
  always_comb begin
    address_d = address_q;
    length_d  = length_q;
    fixed_d   = fixed_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    used_d    = used_q;

    if (push_c)   wr_ptr_d = wr_ptr_q + FIFODEPTH_LOG2'(1);
    if (accept_c) rd_ptr_d = rd_ptr_q + FIFODEPTH_LOG2'(1);

    case ({push_c, accept_c})
      2'b10:   used_d = used_q + USEDW'(1);
      2'b01:   used_d = used_q - USEDW'(1);
      default: used_d = used_q;
    endcase

    // A new go wins over a same-cycle accept; the popped word is still consumed.
    if (control_go) begin
      address_d = control_write_base;
      length_d  = control_write_length & LEN_MASK;
      fixed_d   = control_fixed_location;
    end else if (accept_c) begin
      length_d = length_q - STEP;
      if (!fixed_q) address_d = address_q + STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      address_q <= '0;
      length_q  <= '0;
      fixed_q   <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      used_q    <= '0;
    end else begin
      address_q <= address_d;
      length_q  <= length_d;
      fixed_q   <= fixed_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      used_q    <= used_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by the count and pointers.
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= user_buffer_data;
  end

  assign master_write      = write_c;
  assign master_address    = address_q;
  assign master_writedata  = mem_q[rd_ptr_q];
  assign master_byteenable = '1;
  assign control_done      = (length_q == '0);
  assign user_buffer_full  = full_c;

endmodule

// File: tb/tb_latency_aware_write_master.sv
// Scoreboard bench for latency_aware_write_master: expected (address, data) pairs
// are queued as stimulus is driven and retired by a monitor on each accepted write.
`timescale 1ns/1ps
module tb_latency_aware_write_master;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        control_fixed_location;
  logic [31:0] control_write_base;
  logic [31:0] control_write_length;
  logic        control_go;
  logic        control_done;
  logic        user_write_buffer;
  logic [31:0] user_buffer_data;
  logic        user_buffer_full;
  logic [31:0] master_address;
  logic        master_write;
  logic [3:0]  master_byteenable;
  logic [31:0] master_writedata;
  logic        master_waitrequest;

  int   tests_run;
  int   tests_failed;
  exp_t sb [$];

  latency_aware_write_master dut (
    .clk                    (clk),
    .reset                  (reset),
    .control_fixed_location (control_fixed_location),
    .control_write_base     (control_write_base),
    .control_write_length   (control_write_length),
    .control_go             (control_go),
    .control_done           (control_done),
    .user_write_buffer      (user_write_buffer),
    .user_buffer_data       (user_buffer_data),
    .user_buffer_full       (user_buffer_full),
    .master_address         (master_address),
    .master_write           (master_write),
    .master_byteenable      (master_byteenable),
    .master_writedata       (master_writedata),
    .master_waitrequest     (master_waitrequest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Retire one expected entry for every write the slave accepts at the coming edge.
  always @(negedge clk) begin
    if (reset === 1'b1 && master_write === 1'b1 && master_waitrequest === 1'b0) begin
      exp_t e;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_write: addr=%h data=%h, required no write", master_address, master_writedata);
      end else begin
        e = sb.pop_front();
        if (master_address !== e.addr || master_writedata !== e.data) begin
          tests_failed++;
          $display("FAIL write_beat: addr=%h data=%h, required addr=%h data=%h",
                   master_address, master_writedata, e.addr, e.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    user_write_buffer = 1'b1;
    user_buffer_data  = d;
    tick();
    user_write_buffer = 1'b0;
  endtask

  task automatic go(input logic [31:0] base, input logic [31:0] len, input logic fixed);
    control_write_base     = base;
    control_write_length   = len;
    control_fixed_location = fixed;
    control_go             = 1'b1;
    tick();
    control_go             = 1'b0;
  endtask

  task automatic wait_drain(input int budget, output logic drained);
    drained = (sb.size() == 0);
    for (int i = 0; i < budget && !drained; i++) begin
      tick();
      drained = (sb.size() == 0);
    end
    if (!drained) sb.delete();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tests_run += 4;
    if (master_write !== 1'b0) begin tests_failed++; $display("FAIL reset_write: got %b, required 0", master_write); end
    if (control_done !== 1'b1) begin tests_failed++; $display("FAIL reset_done: got %b, required 1", control_done); end
    if (user_buffer_full !== 1'b0) begin tests_failed++; $display("FAIL reset_full: got %b, required 0", user_buffer_full); end
    if (master_byteenable !== 4'hF) begin tests_failed++; $display("FAIL reset_byteenable: got %h, required f", master_byteenable); end
  endtask

  task automatic test_basic();
    logic drained;
    for (int i = 0; i < 4; i++) sb.push_back('{32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i)});
    go(32'h1000, 32'd16, 1'b0);
    tests_run += 2;
    if (control_done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_busy: got %b, required 0", control_done); end
    if (master_write !== 1'b0) begin tests_failed++; $display("FAIL basic_write_empty: got %b, required 0", master_write); end
    push_word(32'hA000_0000);
    tests_run += 2;
    if (master_write !== 1'b1) begin tests_failed++; $display("FAIL basic_showahead_write: got %b, required 1", master_write); end
    if (master_writedata !== 32'hA000_0000) begin tests_failed++; $display("FAIL basic_showahead_data: got %h, required a0000000", master_writedata); end
    for (int i = 1; i < 4; i++) push_word(32'hA000_0000 + 32'(i));
    wait_drain(20, drained);
    tests_run += 2;
    if (!drained) begin tests_failed++; $display("FAIL basic_drain: timed out, required 4 writes"); end
    if (control_done !== 1'b1) begin tests_failed++; $display("FAIL basic_done: got %b, required 1", control_done); end
  endtask

  task automatic test_stall();
    logic drained;
    for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) sb.push_back('{32'h1000 + 32'(4 * i), 32'hA000_0000 + 32'(i)});
    go(32'h1000, 32'd16, 1'b0);
    tests_run += 2;
    if (master_write !== 1'b1) begin tests_failed++; $display("FAIL stall_first_write: got %b, required 1", master_write); end
    if (master_address !== 32'h1000) begin tests_failed++; $display("FAIL stall_first_addr: got %h, required 00001000", master_address); end
    tick();
    master_waitrequest = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tests_run++;
      if (master_write !== 1'b1 || master_address !== 32'h1004 || master_writedata !== 32'hA000_0001) begin
        tests_failed++;
        $display("FAIL stall_hold: write=%b addr=%h data=%h, required 1 00001004 a0000001",
                 master_write, master_address, master_writedata);
      end
      tick();
    end
    master_waitrequest = 1'b0;
    wait_drain(20, drained);
    tests_run += 2;
    if (!drained) begin tests_failed++; $display("FAIL stall_drain: timed out, required 4 writes"); end
    if (control_done !== 1'b1) begin tests_failed++; $display("FAIL stall_done: got %b, required 1", control_done); end
  endtask

  task automatic test_full();
    logic drained;
    for (int i = 0; i < 31; i++) push_word(32'hD000_0000 + 32'(i));
    tests_run++;
    if (user_buffer_full !== 1'b0) begin tests_failed++; $display("FAIL full_at_31: got %b, required 0", user_buffer_full); end
    push_word(32'hD000_001F);
    tests_run++;
    if (user_buffer_full !== 1'b1) begin tests_failed++; $display("FAIL full_at_32: got %b, required 1", user_buffer_full); end
    push_word(32'hDEAD_BEEF);
    tests_run++;
    if (user_buffer_full !== 1'b1) begin tests_failed++; $display("FAIL full_after_drop: got %b, required 1", user_buffer_full); end
    for (int i = 0; i < 32; i++) sb.push_back('{32'h3000 + 32'(4 * i), 32'hD000_0000 + 32'(i)});
    go(32'h3000, 32'd128, 1'b0);
    wait_drain(80, drained);
    tests_run += 3;
    if (!drained) begin tests_failed++; $display("FAIL full_drain: timed out, required 32 writes"); end
    if (control_done !== 1'b1) begin tests_failed++; $display("FAIL full_done: got %b, required 1", control_done); end
    if (user_buffer_full !== 1'b0) begin tests_failed++; $display("FAIL full_cleared: got %b, required 0", user_buffer_full); end
  endtask

  task automatic test_fixed_mask();
    logic drained;
    sb.push_back('{32'h20, 32'hE000_0000});
    sb.push_back('{32'h20, 32'hE000_0001});
    go(32'h20, 32'd10, 1'b1);
    for (int i = 0; i < 3; i++) push_word(32'hE000_0000 + 32'(i));
    wait_drain(20, drained);
    tests_run += 2;
    if (!drained) begin tests_failed++; $display("FAIL fixed_drain: timed out, required 2 writes"); end
    if (control_done !== 1'b1) begin tests_failed++; $display("FAIL fixed_done: got %b, required 1", control_done); end
    tick();
    tick();
    tests_run++;
    if (master_write !== 1'b0) begin tests_failed++; $display("FAIL fixed_leftover_idle: got %b, required 0", master_write); end
  endtask

  task automatic test_mid_go();
    logic drained;
    master_waitrequest = 1'b1;
    go(32'h1800, 32'd16, 1'b0);
    for (int i = 0; i < 3; i++) push_word(32'hF000_0000 + 32'(i));
    sb.push_back('{32'h1800, 32'hE000_0002});
    sb.push_back('{32'h1804, 32'hF000_0000});
    sb.push_back('{32'h1808, 32'hF000_0001});
    sb.push_back('{32'h2000, 32'hF000_0002});
    sb.push_back('{32'h2004, 32'hF000_0003});
    master_waitrequest = 1'b0;
    tick();
    tick();
    go(32'h2000, 32'd8, 1'b0);
    tests_run += 2;
    if (master_address !== 32'h2000) begin tests_failed++; $display("FAIL midgo_addr: got %h, required 00002000", master_address); end
    if (master_writedata !== 32'hF000_0002) begin tests_failed++; $display("FAIL midgo_data: got %h, required f0000002", master_writedata); end
    push_word(32'hF000_0003);
    wait_drain(20, drained);
    tests_run += 2;
    if (!drained) begin tests_failed++; $display("FAIL midgo_drain: timed out, required 5 writes"); end
    if (control_done !== 1'b1) begin tests_failed++; $display("FAIL midgo_done: got %b, required 1", control_done); end
  endtask

  task automatic test_mid_reset();
    logic drained;
    master_waitrequest = 1'b1;
    go(32'h4000, 32'd16, 1'b0);
    push_word(32'hC000_0000);
    push_word(32'hC000_0001);
    tests_run++;
    if (master_write !== 1'b1) begin tests_failed++; $display("FAIL rst_pre_write: got %b, required 1", master_write); end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    master_waitrequest = 1'b0;
    tests_run += 2;
    if (master_write !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_write: got %b, required 0", master_write); end
    if (control_done !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_done: got %b, required 1", control_done); end
    tick();
    tick();
    sb.push_back('{32'h5000, 32'hBB00_0000});
    go(32'h5000, 32'd4, 1'b0);
    push_word(32'hBB00_0000);
    wait_drain(20, drained);
    tests_run += 2;
    if (!drained) begin tests_failed++; $display("FAIL rst_after_drain: timed out, required 1 write"); end
    if (control_done !== 1'b1) begin tests_failed++; $display("FAIL rst_after_done: got %b, required 1", control_done); end
  endtask

  initial begin
    tests_run              = 0;
    tests_failed           = 0;
    reset                  = 1'b0;
    control_fixed_location = 1'b0;
    control_write_base     = '0;
    control_write_length   = '0;
    control_go             = 1'b0;
    user_write_buffer      = 1'b0;
    user_buffer_data       = '0;
    master_waitrequest     = 1'b0;

    test_reset();
    test_basic();
    test_stall();
    test_full();
    test_fixed_mask();
    test_mid_go();
    test_mid_reset();
    tick();
    tick();
    tests_run++;
    if (sb.size() != 0) begin tests_failed++; $display("FAIL scoreboard_leftover: %0d entries, required 0", sb.size()); end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
